alu_op_dispatcher: RTL and testbench

//  Issue side of the ALU result path. Accepts one ALU operation (op, a, b) and

---
 rtl/alu_pkg.sv | 25 ++
 rtl/dispatch_timer.sv | 38 +++
 rtl/alu_op_dispatcher.sv | 143 ++++++++++++++
 tb/tb_alu_op_dispatcher.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path.
//   op_e    : operation code, also used as the result-mux select
//   state_e : dispatcher FSM state encoding
//   op_onehot() : converts an op code to the one-hot unit start vector
package alu_pkg;

   typedef enum logic [1:0] {
      OP_SUM   = 2'b00,
      OP_AND   = 2'b01,
      OP_OR    = 2'b10,
      OP_SHIFT = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10,
      RESP  = 2'b11
   } state_e;

   function automatic logic [3:0] op_onehot(input logic [1:0] op);
      op_onehot = 4'b0001 << op;
   endfunction

endpackage

// File: rtl/dispatch_timer.sv
// Wait-phase timer for the ALU dispatcher.
//   clk, rst_n : clock and async active-low reset
//   clr        : force count to zero (held while not waiting)
//   inc        : advance count by one
//   tc         : count has reached TIMEOUT-1
module dispatch_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic tc
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [TW-1:0] cnt_q, cnt_d;

   assign tc = (cnt_q == TW'(TIMEOUT - 1));

   // Saturates at the terminal value so the count can never wrap.
   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && !tc)
         cnt_d = cnt_q + TW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/alu_op_dispatcher.sv
// Issue side of the ALU result path: accepts one operation, starts the
// matching function unit, waits for it (with timeout) and presents the
// result-mux select until the consumer takes the result.
//   in_*      : request handshake and operands
//   u_*       : one-hot unit start, broadcast operands, unit handshakes
//   res_*     : result-mux select, result valid/error, consumer ready
//   spurious  : sticky flag, done seen from a unit that was not started
//   op_count  : retired operations (including timed-out ones), wraps
//
// state | meaning
// ------+--------------------------------------------------------
// IDLE  | ready for a request; operands latched on accept
// ISSUE | start asserted to the selected unit until it accepts
// WAIT  | waiting for the unit's done, timer running
// RESP  | result valid on the mux, held until consumer takes it
module alu_op_dispatcher
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [3:0]       u_valid,
   input  logic [3:0]       u_ready,
   output logic [WIDTH-1:0] u_a,
   output logic [WIDTH-1:0] u_b,
   input  logic [3:0]       u_done,
   output logic [1:0]       res_sel,
   output logic             res_valid,
   output logic             res_err,
   input  logic             res_ready,
   output logic             spurious,
   output logic [CNT_W-1:0] op_count
);

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             err_q, err_d;
   logic             spur_q, spur_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             tmr_clr;
   logic             tmr_inc;
   logic             tmr_tc;

   dispatch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (tmr_clr),
      .inc   (tmr_inc),
      .tc    (tmr_tc)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      tmr_clr = 1'b1;
      tmr_inc = 1'b0;
      // Any done from a unit other than the selected one is a protocol
      // violation; only meaningful while an operation is in flight.
      spur_d  = spur_q | ((state_q != IDLE) && (|(u_done & ~op_onehot(op_q))));

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               op_d    = op_e'(in_op);
               a_d     = in_a;
               b_d     = in_b;
               err_d   = 1'b0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (u_ready[op_q])
               state_d = WAIT;
         end
         WAIT: begin
            tmr_clr = 1'b0;
            tmr_inc = 1'b1;
            // done has priority over a timeout in the same cycle
            if (u_done[op_q]) begin
               err_d   = 1'b0;
               state_d = RESP;
            end else if (tmr_tc) begin
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            if (res_ready) begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= OP_SUM;
         a_q     <= '0;
         b_q     <= '0;
         err_q   <= 1'b0;
         spur_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         err_q   <= err_d;
         spur_q  <= spur_d;
         cnt_q   <= cnt_d;
      end
   end

   // Decoded from state so reset drops the unit start immediately.
   assign in_ready  = (state_q == IDLE);
   assign u_valid   = (state_q == ISSUE) ? op_onehot(op_q) : 4'b0000;
   assign u_a       = a_q;
   assign u_b       = b_q;
   assign res_sel   = op_q;
   assign res_valid = (state_q == RESP);
   assign res_err   = res_valid & err_q;
   assign spurious  = spur_q;
   assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_op_dispatcher.sv
module tb_alu_op_dispatcher;

   localparam int WIDTH   = 32;
   localparam int TIMEOUT = 15;
   localparam int CNT_W   = 8;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_op;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [3:0]       u_valid;
   logic [3:0]       u_ready;
   logic [WIDTH-1:0] u_a;
   logic [WIDTH-1:0] u_b;
   logic [3:0]       u_done;
   logic [1:0]       res_sel;
   logic             res_valid;
   logic             res_err;
   logic             res_ready;
   logic             spurious;
   logic [CNT_W-1:0] op_count;

   alu_op_dispatcher #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_a      (in_a),
      .in_b      (in_b),
      .u_valid   (u_valid),
      .u_ready   (u_ready),
      .u_a       (u_a),
      .u_b       (u_b),
      .u_done    (u_done),
      .res_sel   (res_sel),
      .res_valid (res_valid),
      .res_err   (res_err),
      .res_ready (res_ready),
      .spurious  (spurious),
      .op_count  (op_count)
   );

   typedef struct {
      logic [1:0] op;
      logic       err;
   } exp_t;

   exp_t             sb[$];
   int               total = 0;
   int               bad   = 0;
   logic [CNT_W-1:0] exp_cnt = '0;
   logic             exp_spur = 1'b0;
   int               lat;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Runs one operation from the IDLE negedge to the negedge after retirement.
   // rdly: extra ISSUE cycles before u_ready; ddly: WAIT cycle index of done
   // (>= TIMEOUT means the unit never answers); spur: stray done bits pulsed
   // in the first WAIT cycle.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int rdly, input int ddly, input logic [3:0] spur,
                         output int latency);
      exp_t       e;
      logic [3:0] oh;
      int         n;
      oh = 4'b0001 << op;
      chk("idle_in_ready", {31'd0, in_ready}, 1);
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      if (rdly == 0) u_ready = oh;
      e.op  = op;
      e.err = (ddly >= TIMEOUT);
      sb.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      latency  = 1;
      chk("issue_u_valid", {28'd0, u_valid}, {28'd0, oh});
      chk("issue_u_a", u_a, a);
      chk("issue_u_b", u_b, b);
      chk("issue_res_sel", {30'd0, res_sel}, {30'd0, op});
      chk("issue_in_ready", {31'd0, in_ready}, 0);
      for (int i = 0; i < rdly; i++) begin
         @(negedge clk);
         latency++;
         chk("issue_hold", {28'd0, u_valid}, {28'd0, oh});
      end
      u_ready = oh;
      @(negedge clk);
      latency++;
      u_ready = 4'b0000;
      chk("wait_u_valid", {28'd0, u_valid}, 0);
      n = 0;
      while (!res_valid && n < TIMEOUT + 5) begin
         u_done = 4'b0000;
         if (n == 0) u_done = u_done | spur;
         if (n == ddly) u_done = u_done | oh;
         @(negedge clk);
         latency++;
         n++;
      end
      u_done = 4'b0000;
      if (spur != 4'b0000) exp_spur = 1'b1;
      if (!res_valid) begin
         total++;
         bad++;
         $display("FAIL res_valid_timeout got=0 exp=1");
         void'(sb.pop_front());
         return;
      end
      chk("wait_cycles", n, e.err ? TIMEOUT : ddly + 1);
      e = sb.pop_front();
      chk("res_sel", {30'd0, res_sel}, {30'd0, e.op});
      chk("res_err", {31'd0, res_err}, {31'd0, e.err});
      if (rdly > 0) begin
         @(negedge clk);
         chk("resp_hold", {31'd0, res_valid}, 1);
         chk("resp_hold_sel", {30'd0, res_sel}, {30'd0, e.op});
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      exp_cnt   = exp_cnt + 1'b1;
      chk("post_in_ready", {31'd0, in_ready}, 1);
      chk("post_res_valid", {31'd0, res_valid}, 0);
      chk("op_count", {24'd0, op_count}, {24'd0, exp_cnt});
      chk("spurious", {31'd0, spurious}, {31'd0, exp_spur});
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_op     = 2'b00;
      in_a      = '0;
      in_b      = '0;
      u_ready   = 4'b0000;
      u_done    = 4'b0000;
      res_ready = 1'b0;
      #12;
      chk("rst_in_ready", {31'd0, in_ready}, 1);
      chk("rst_u_valid", {28'd0, u_valid}, 0);
      chk("rst_res_valid", {31'd0, res_valid}, 0);
      chk("rst_op_count", {24'd0, op_count}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // sum, immediate ready and done: minimum latency
      run_op(2'b00, 32'd5, 32'd7, 0, 0, 4'b0000, lat);
      chk("t1_latency", lat, 3);
      // shift with delayed u_ready
      run_op(2'b11, 32'hDEAD_BEEF, 32'd4, 4, 2, 4'b0000, lat);
      // or, unit never answers: timeout
      run_op(2'b10, 32'h1234_5678, 32'h0F0F_0F0F, 0, 1000, 4'b0000, lat);
      // done in the same cycle as the timeout: done wins
      run_op(2'b00, 32'd1, 32'd2, 1, TIMEOUT - 1, 4'b0000, lat);
      // and, stray done from the or unit, then normal retirement
      run_op(2'b01, 32'hFFFF_0000, 32'h00FF_FF00, 0, 2, 4'b0100, lat);
      run_op(2'b11, 32'h8000_0001, 32'd31, 0, 0, 4'b0000, lat);
      chk("spur_sticky", {31'd0, spurious}, 1);

      // reset while waiting on a unit
      in_valid = 1'b1;
      in_op    = 2'b10;
      in_a     = 32'hA5A5_A5A5;
      in_b     = 32'h5A5A_5A5A;
      @(negedge clk);
      in_valid = 1'b0;
      u_ready  = 4'b0100;
      @(negedge clk);
      u_ready  = 4'b0000;
      @(negedge clk);
      chk("pre_rst_state", {31'd0, in_ready | res_valid}, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_in_ready", {31'd0, in_ready}, 1);
      chk("arst_u_valid", {28'd0, u_valid}, 0);
      chk("arst_u_a", u_a, 0);
      chk("arst_u_b", u_b, 0);
      chk("arst_res_sel", {30'd0, res_sel}, 0);
      chk("arst_res_valid", {31'd0, res_valid}, 0);
      chk("arst_res_err", {31'd0, res_err}, 0);
      chk("arst_spurious", {31'd0, spurious}, 0);
      chk("arst_op_count", {24'd0, op_count}, 0);
      @(negedge clk);
      rst_n    = 1'b1;
      exp_cnt  = '0;
      exp_spur = 1'b0;
      @(negedge clk);
      run_op(2'b01, 32'h0000_00F0, 32'h0000_00FF, 0, 0, 4'b0000, lat);

      // back-to-back traffic until the counter wraps
      for (int k = 0; k < (1 << CNT_W) - 1; k++) begin
         run_op(2'($urandom_range(3)), $urandom, $urandom, 0, 0, 4'b0000, lat);
      end
      chk("wrap_op_count", {24'd0, op_count}, 0);
      chk("sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
